// File: rtl/count_seq_checker_pkg.sv
// Shared types and default widths for the count-sequence checker and its
// saturating error counter.
package count_seq_checker_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ERR_W = 8;

endpackage

// File: rtl/count_seq_checker_if.sv
// Sample stream in, lock/error status out, for the count-sequence checker.
interface count_seq_checker_if
    import count_seq_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output data_in, data_valid, clr_err,
        input  locked, err_pulse, err_count, expected
    );

    modport slave (
        input  data_in, data_valid, clr_err,
        output locked, err_pulse, err_count, expected
    );
endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module sat_counter
    import count_seq_checker_pkg::*;
#(
    parameter int W = DEF_ERR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/count_seq_checker.sv
// Checks that a sampled count stream increments by one per valid sample,
// acquiring and dropping lock and counting in-lock sequence errors.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic                clk,
    input  logic                rst,
    count_seq_checker_if.slave  bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] expected_reg, expected_next;
    logic [MW-1:0]    match_cnt_reg, match_cnt_next;
    logic [LW-1:0]    miss_cnt_reg, miss_cnt_next;
    logic             locked_reg, locked_next;
    logic             err_pulse_reg, err_pulse_next;
    logic             err_inc;
    logic             hit;

    assign hit = (bus.data_in == expected_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SEARCH;
            expected_reg  <= '0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            expected_reg  <= expected_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        expected_next  = expected_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        err_pulse_next = 1'b0;
        err_inc        = 1'b0;
        if (bus.data_valid) begin
            case (state_reg)
                SEARCH: begin
                    expected_next  = bus.data_in + WIDTH'(1);
                    match_cnt_next = MW'(1);
                    state_next     = LOCKING;
                end
                LOCKING: begin
                    if (hit) begin
                        expected_next  = expected_reg + WIDTH'(1);
                        match_cnt_next = match_cnt_reg + MW'(1);
                        if (match_cnt_reg + MW'(1) == MW'(LOCK_CNT)) begin
                            state_next     = LOCKED;
                            match_cnt_next = '0;
                        end
                    end else begin
                        expected_next  = bus.data_in + WIDTH'(1);
                        match_cnt_next = MW'(1);
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        expected_next = expected_reg + WIDTH'(1);
                        miss_cnt_next = '0;
                    end else begin
                        // Reseed from the sample so a single slip costs one error only.
                        expected_next  = bus.data_in + WIDTH'(1);
                        err_pulse_next = 1'b1;
                        err_inc        = 1'b1;
                        miss_cnt_next  = miss_cnt_reg + LW'(1);
                        if (miss_cnt_reg + LW'(1) == LW'(LOSS_CNT)) begin
                            state_next    = SEARCH;
                            miss_cnt_next = '0;
                        end
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
        locked_next = (state_next == LOCKED);
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (bus.clr_err),
        .count (bus.err_count)
    );

    assign bus.locked    = locked_reg;
    assign bus.err_pulse = err_pulse_reg;
    assign bus.expected  = expected_reg;
endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker: lock, wrap, slip, loss, saturation,
// gaps and reset, with hand-computed expectations.
module tb_count_seq_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    count_seq_checker_if #(.WIDTH(8), .ERR_W(8)) bus1 ();
    count_seq_checker_if #(.WIDTH(8), .ERR_W(8)) bus2 ();

    count_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .LOSS_CNT(2), .ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    count_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .LOSS_CNT(1000), .ERR_W(8)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // One clock with the given inputs on bus1; outputs settle by #1 after the edge.
    task automatic step1(input logic [7:0] v, input logic vld);
        @(negedge clk);
        bus1.data_in    = v;
        bus1.data_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic [7:0] v, input logic clr);
        @(negedge clk);
        bus2.data_in    = v;
        bus2.data_valid = 1'b1;
        bus2.clr_err    = clr;
        @(posedge clk);
        #1;
        bus2.data_valid = 1'b0;
        bus2.clr_err    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        bus1.data_valid = 1'b0;
        bus2.data_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic lock_from(input logic [7:0] start);
        for (int i = 0; i < 4; i++) step1(start + 8'(i), 1'b1);
        step1(8'd0, 1'b0);
    endtask

    initial begin
        bus1.data_in = '0; bus1.data_valid = 1'b0; bus1.clr_err = 1'b0;
        bus2.data_in = '0; bus2.data_valid = 1'b0; bus2.clr_err = 1'b0;

        do_reset();
        check("rst_locked", bus1.locked, 0);
        check("rst_pulse", bus1.err_pulse, 0);
        check("rst_errcnt", bus1.err_count, 0);
        check("rst_expected", bus1.expected, 0);

        // 1: lock on 10..13
        step1(8'd10, 1); step1(8'd11, 1); step1(8'd12, 1);
        check("t1_not_yet_locked", bus1.locked, 0);
        step1(8'd13, 1);
        check("t1_locked", bus1.locked, 1);
        check("t1_expected", bus1.expected, 14);
        check("t1_errcnt", bus1.err_count, 0);

        // 2: wrap through 255 -> 0 while locked
        do_reset();
        lock_from(8'd250);
        step1(8'd254, 1); step1(8'd255, 1);
        check("t2_pulse_255", bus1.err_pulse, 0);
        step1(8'd0, 1);
        check("t2_pulse_0", bus1.err_pulse, 0);
        step1(8'd1, 1);
        check("t2_locked", bus1.locked, 1);
        check("t2_expected", bus1.expected, 2);
        check("t2_errcnt", bus1.err_count, 0);

        // 3: single slip
        do_reset();
        lock_from(8'd16);
        check("t3_expected_pre", bus1.expected, 20);
        step1(8'd22, 1);
        check("t3_pulse", bus1.err_pulse, 1);
        check("t3_errcnt", bus1.err_count, 1);
        check("t3_locked_mid", bus1.locked, 1);
        step1(8'd23, 1);
        check("t3_pulse_clear", bus1.err_pulse, 0);
        check("t3_locked", bus1.locked, 1);
        check("t3_expected", bus1.expected, 24);

        // 4: loss of lock then relock
        do_reset();
        lock_from(8'd26);
        step1(8'd50, 1);
        check("t4_pulse1", bus1.err_pulse, 1);
        check("t4_locked_mid", bus1.locked, 1);
        step1(8'd70, 1);
        check("t4_pulse2", bus1.err_pulse, 1);
        check("t4_errcnt", bus1.err_count, 2);
        check("t4_unlocked", bus1.locked, 0);
        check("t4_state", dut.state_reg, 0);
        step1(8'd5, 1); step1(8'd6, 1); step1(8'd7, 1); step1(8'd8, 1);
        check("t4_relocked", bus1.locked, 1);
        check("t4_reexpected", bus1.expected, 9);

        // 5: saturation and clear on the high-LOSS_CNT instance
        for (int i = 1; i <= 4; i++) step2(8'(i), 1'b0);
        check("t5_locked", bus2.locked, 1);
        for (int i = 0; i < 254; i++) step2(8'd100, 1'b0);
        check("t5_errcnt_254", bus2.err_count, 254);
        step2(8'd100, 1'b0);
        check("t5_errcnt_255", bus2.err_count, 255);
        for (int i = 0; i < 45; i++) step2(8'd100, 1'b0);
        check("t5_errcnt_sat", bus2.err_count, 255);
        check("t5_still_locked", bus2.locked, 1);
        step2(8'd100, 1'b1);
        check("t5_clr_errcnt", bus2.err_count, 0);
        check("t5_clr_pulse", bus2.err_pulse, 1);
        step2(8'd100, 1'b0);
        check("t5_after_clr", bus2.err_count, 1);

        // 6: valid gaps, then reset mid-lock
        do_reset();
        step1(8'd40, 1); step1(8'd0, 0);
        step1(8'd41, 1); step1(8'd0, 0);
        check("t6_gap_pulse", bus1.err_pulse, 0);
        step1(8'd42, 1); step1(8'd0, 0);
        check("t6_gap_unlocked", bus1.locked, 0);
        check("t6_gap_expected", bus1.expected, 43);
        step1(8'd43, 1);
        check("t6_locked", bus1.locked, 1);
        check("t6_expected", bus1.expected, 44);
        step1(8'd99, 1);
        check("t6_errcnt_pre", bus1.err_count, 1);
        do_reset();
        check("t6_rst_locked", bus1.locked, 0);
        check("t6_rst_expected", bus1.expected, 0);
        check("t6_rst_errcnt", bus1.err_count, 0);
        check("t6_rst_pulse", bus1.err_pulse, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
